fft_tw_mul: RTL and testbench

//  Twiddle-applying stage between FFT butterfly stages; the consumer side of the twiddle ROMs (mem_tw*).

---
 rtl/fft_tw_mul.sv | 140 ++++++++++++++
 tb/tb_fft_tw_mul.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_tw_mul.sv
// fft_tw_mul: twiddle-applying stage between FFT butterfly stages.
// Counts the incoming complex sample stream, drives a registered address to an
// external combinational twiddle ROM, multiplies each sample by the returned
// twiddle, then rounds (half-up) and saturates. Fixed 3-register latency,
// full throughput, no backpressure.
//
// Ports:
//   clk, rstn            clock (rising edge), async active-low reset
//   din_valid/din_sof    input strobe and first-of-frame flag
//   din_re/din_im        signed input sample (DW)
//   tw_addr              registered twiddle ROM address (AW)
//   tw_re/tw_im          ROM data, combinational from tw_addr (TW, FRAC frac bits)
//   dout_valid/dout_sof  output strobe and first-of-frame flag
//   dout_re/dout_im      rounded, saturated product (DW)
//   dout_sat             saturation occurred on re or im of this output
module fft_tw_mul #(
  parameter int DW   = 10,
  parameter int TW   = 10,
  parameter int FRAC = 7,
  parameter int AW   = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 din_valid,
  input  logic                 din_sof,
  input  logic signed [DW-1:0] din_re,
  input  logic signed [DW-1:0] din_im,
  output logic        [AW-1:0] tw_addr,
  input  logic signed [TW-1:0] tw_re,
  input  logic signed [TW-1:0] tw_im,
  output logic                 dout_valid,
  output logic                 dout_sof,
  output logic signed [DW-1:0] dout_re,
  output logic signed [DW-1:0] dout_im,
  output logic                 dout_sat
);

  localparam int PW = DW + TW + 1;

  localparam logic signed [PW:0] RND  = (PW+1)'(2 ** (FRAC - 1));
  localparam logic signed [PW:0] MAXV = (PW+1)'(2 ** (DW - 1) - 1);
  localparam logic signed [PW:0] MINV = -((PW+1)'(2 ** (DW - 1)));

  logic        [AW-1:0] cnt;
  logic        [AW-1:0] idx;
  logic                 s1_valid, s1_sof;
  logic signed [DW-1:0] s1_re, s1_im;
  logic                 s2_valid, s2_sof;
  logic signed [PW-1:0] s2_pr, s2_pi;
  logic signed [PW-1:0] pr_c, pi_c;
  logic        [DW:0]   re_rs, im_rs;

  // sof restarts the period at index 0 regardless of the running count
  assign idx = din_sof ? '0 : cnt;

  // S1: capture sample and present its twiddle address
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      tw_addr  <= '0;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
    end else begin
      s1_valid <= din_valid;
      if (din_valid) begin
        s1_re   <= din_re;
        s1_im   <= din_im;
        s1_sof  <= din_sof;
        tw_addr <= idx;
        cnt     <= idx + AW'(1);
      end
    end
  end

  // Full-precision complex multiply; operands sign-extended to PW first so
  // the products and sums are exact.
  always_comb begin
    logic signed [PW-1:0] a_re, a_im, b_re, b_im;
    a_re = PW'(s1_re);
    a_im = PW'(s1_im);
    b_re = PW'(tw_re);
    b_im = PW'(tw_im);
    pr_c = (a_re * b_re) - (a_im * b_im);
    pi_c = (a_re * b_im) + (a_im * b_re);
  end

  // S2: register products
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_pr    <= '0;
      s2_pi    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_valid & s1_sof;
      if (s1_valid) begin
        s2_pr <= pr_c;
        s2_pi <= pi_c;
      end
    end
  end

  // Round half-up then clamp; result is {sat_flag, value}.
  // One guard bit is added so the rounding constant can never overflow.
  function automatic logic [DW:0] rnd_sat(input logic signed [PW-1:0] p);
    logic signed [PW:0] r;
    r = ($signed({p[PW-1], p}) + RND) >>> FRAC;
    if (r > MAXV)      rnd_sat = {1'b1, MAXV[DW-1:0]};
    else if (r < MINV) rnd_sat = {1'b1, MINV[DW-1:0]};
    else               rnd_sat = {1'b0, r[DW-1:0]};
  endfunction

  always_comb begin
    re_rs = rnd_sat(s2_pr);
    im_rs = rnd_sat(s2_pi);
  end

  // S3: output register; data holds on cycles without a valid output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      dout_sat   <= 1'b0;
    end else begin
      dout_valid <= s2_valid;
      dout_sof   <= s2_valid & s2_sof;
      if (s2_valid) begin
        dout_re  <= $signed(re_rs[DW-1:0]);
        dout_im  <= $signed(im_rs[DW-1:0]);
        dout_sat <= re_rs[DW] | im_rs[DW];
      end
    end
  end

endmodule

// File: tb/tb_fft_tw_mul.sv
module tb_fft_tw_mul;

  logic              clk = 1'b0;
  logic              rstn;
  logic              din_valid, din_sof;
  logic signed [9:0] din_re, din_im;
  logic        [1:0] tw_addr;
  logic signed [9:0] tw_re, tw_im;
  logic              dout_valid, dout_sof, dout_sat;
  logic signed [9:0] dout_re, dout_im;

  logic signed [9:0] rom_re [4];
  logic signed [9:0] rom_im [4];

  assign tw_re = rom_re[tw_addr];
  assign tw_im = rom_im[tw_addr];

  always #5 clk = ~clk;

  fft_tw_mul #(.DW(10), .TW(10), .FRAC(7), .AW(2)) dut (
    .clk(clk), .rstn(rstn),
    .din_valid(din_valid), .din_sof(din_sof),
    .din_re(din_re), .din_im(din_im),
    .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .dout_valid(dout_valid), .dout_sof(dout_sof),
    .dout_re(dout_re), .dout_im(dout_im), .dout_sat(dout_sat)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model state
  typedef struct { bit v; bit sof; int re; int im; bit sat; } ent_t;
  ent_t pipe [3];
  int   m_cnt, m_addr, h_re, h_im;
  bit   h_sat;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // floor((p + 64) / 128) computed with plain integer division
  function automatic int rnd(input int p);
    int q;
    q = p + 64;
    return (q >= 0) ? q / 128 : -((-q + 127) / 128);
  endfunction

  function automatic int clampv(input int r, output bit s);
    s = (r > 511) || (r < -512);
    return (r > 511) ? 511 : (r < -512) ? -512 : r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
    m_cnt = 0; m_addr = 0; h_re = 0; h_im = 0; h_sat = 0;
  endtask

  task automatic check_outputs();
    chk("dout_valid", dout_valid, pipe[2].v);
    chk("dout_sof",   dout_sof,   pipe[2].v & pipe[2].sof);
    chk("dout_re",    dout_re,    h_re);
    chk("dout_im",    dout_im,    h_im);
    chk("dout_sat",   dout_sat,   h_sat);
    chk("tw_addr",    tw_addr,    m_addr);
  endtask

  // Drive one cycle of input, advance one clock, check against the model
  task automatic cyc(input bit v, input bit sof, input int re, input int im);
    ent_t e;
    int   idx, pr, pi, ar, ai;
    bit   sr, si;
    din_valid = v; din_sof = sof;
    din_re = 10'(re); din_im = 10'(im);
    e = '{0, 0, 0, 0, 0};
    if (v) begin
      idx    = sof ? 0 : m_cnt;
      m_cnt  = (idx + 1) % 4;
      m_addr = idx;
      pr = re * int'(rom_re[idx]) - im * int'(rom_im[idx]);
      pi = re * int'(rom_im[idx]) + im * int'(rom_re[idx]);
      ar = clampv(rnd(pr), sr);
      ai = clampv(rnd(pi), si);
      e  = '{1, sof, ar, ai, sr | si};
    end
    @(posedge clk); #1;
    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
    if (pipe[2].v) begin
      h_re = pipe[2].re; h_im = pipe[2].im; h_sat = pipe[2].sat;
    end
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, $urandom_range(0, 1023) - 512, 7);
  endtask

  task automatic check_zero();
    chk("rst_valid", dout_valid, 0);
    chk("rst_sof",   dout_sof,   0);
    chk("rst_re",    dout_re,    0);
    chk("rst_im",    dout_im,    0);
    chk("rst_sat",   dout_sat,   0);
    chk("rst_addr",  tw_addr,    0);
  endtask

  task automatic set_rom(input int r0, i0, r1, i1, r2, i2, r3, i3);
    rom_re[0] = 10'(r0); rom_im[0] = 10'(i0);
    rom_re[1] = 10'(r1); rom_im[1] = 10'(i1);
    rom_re[2] = 10'(r2); rom_im[2] = 10'(i2);
    rom_re[3] = 10'(r3); rom_im[3] = 10'(i3);
  endtask

  initial begin
    set_rom(128, 0, 128, 0, 128, 0, 0, -128);
    din_valid = 0; din_sof = 0; din_re = 0; din_im = 0;
    model_reset();

    // T1: reset with random inputs, then a single sample
    rstn = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'($urandom); din_sof = 1'($urandom);
      din_re = 10'($urandom); din_im = 10'($urandom);
      @(posedge clk); #1;
      check_zero();
    end
    rstn = 1;
    model_reset();
    cyc(1, 0, 37, -21);
    idle(4);

    // T2: identity period with -j on index 3
    cyc(1, 1, 100, 50);
    cyc(1, 0, 100, 50);
    cyc(1, 0, 100, 50);
    cyc(1, 0, 100, 50);
    idle(3);

    // T3: rounding with constant twiddle (90,0)
    set_rom(90, 0, 90, 0, 90, 0, 90, 0);
    cyc(1, 1, 3, -3);
    cyc(1, 0, 1, 0);
    idle(3);

    // T4: saturation at index 3, then a non-saturating sample
    set_rom(128, 0, 128, 0, 128, 0, 0, -128);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, -512, 0);
    cyc(1, 0, 5, 5);
    idle(3);
    chk("t4_sat_cleared", dout_sat, 0);

    // T5: gaps hold the index; sof mid-period restarts it
    cyc(1, 1, 10, 20);
    cyc(0, 0, 99, 99);
    cyc(0, 0, 99, 99);
    cyc(1, 0, 30, -40);
    cyc(1, 1, -60, 70);
    cyc(1, 0, 5, -5);
    idle(3);

    // T6: reset while samples are in flight
    cyc(1, 0, 200, 100);
    cyc(1, 0, -200, 100);
    cyc(1, 0, 150, -150);
    rstn = 0;
    #1;
    model_reset();
    check_zero();
    @(posedge clk); #1;
    check_zero();
    rstn = 1;
    idle(4);
    cyc(1, 0, 77, 33);
    idle(3);

    // Randomized: random ROM contents per round, random stream
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 4; k++) begin
        rom_re[k] = 10'($urandom);
        rom_im[k] = 10'($urandom);
      end
      for (int i = 0; i < 40; i++)
        cyc($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
            $urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512);
      idle(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
